serial_subtractor_nbit: RTL and testbench

//  - Multi-cycle, bit-serial N-bit subtractor: difference = a - b - borrow_in, one bit per clock, LSB first.
//  - Inverse-direction counterpart of the combinational adder datapath; used where area beats latency.
//  - start/busy/done handshake; operands are latched at start, so the caller may change a/b afterwards.

---
 rtl/serial_subtractor_nbit_pkg.sv | 20 ++
 rtl/serial_subtractor_nbit_full_subtractor.sv | 24 ++
 rtl/serial_subtractor_nbit.sv | 130 +++++++++++++
 tb/tb_serial_subtractor_nbit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_nbit_pkg.sv
//==============================================================================
// Module  : sub_pkg
// Brief   : Shared FSM state encoding and limits for the bit-serial subtractor.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sub_state_t;

   localparam int MAX_WIDTH = 32;

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_nbit_full_subtractor.sv
//==============================================================================
// Module  : full_subtractor
// Brief   : One-bit full subtractor slice: d = a - b - bin, bout = borrow out.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic w_axb;

   assign w_axb = a ^ b;
   assign d     = w_axb ^ bin;
   assign bout  = (~a & b) | (~w_axb & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor_nbit.sv
//==============================================================================
// Module  : serial_subtractor_nbit
// Brief   : Bit-serial N-bit subtractor (a - b - borrow_in), LSB first, with
//           start/busy/done handshake. Macro SUB_OVERFLOW_EN adds signed overflow.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_subtractor_nbit
   import sub_pkg::*;
#(
   parameter int BIT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [BIT_WIDTH-1:0] a,
   input  logic [BIT_WIDTH-1:0] b,
   input  logic                 borrow_in,
   output logic                 busy,
   output logic                 done,
   output logic [BIT_WIDTH-1:0] difference,
   output logic                 borrow_out
`ifdef SUB_OVERFLOW_EN
   ,
   output logic                 overflow
`endif
);

   localparam int                 c_CNT_W = $clog2(BIT_WIDTH);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(BIT_WIDTH - 1);

   sub_state_t r_state;
   sub_state_t w_state_next;

   logic [BIT_WIDTH-1:0] r_a_sr;
   logic [BIT_WIDTH-1:0] r_b_sr;
   // Only BIT_WIDTH-1 bits are kept: the newest bit is folded in combinationally.
   logic [BIT_WIDTH-2:0] r_diff_sr;
   logic [c_CNT_W-1:0]   r_cnt;
   logic                 r_brw;
   logic [BIT_WIDTH-1:0] r_difference;
   logic                 r_borrow_out;

   logic                 w_d;
   logic                 w_bout;
   logic                 w_load;
   logic                 w_last;
   logic [BIT_WIDTH-1:0] w_diff_next;

   full_subtractor u_bit_slice (
      .a    (r_a_sr[0]),
      .b    (r_b_sr[0]),
      .bin  (r_brw),
      .d    (w_d),
      .bout (w_bout)
   );

   assign w_load      = (r_state == IDLE) && start;
   assign w_last      = (r_state == SHIFT) && (r_cnt == c_LAST);
   assign w_diff_next = {w_d, r_diff_sr};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start)  w_state_next = SHIFT;
         SHIFT:   if (w_last) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_sr       <= '0;
         r_b_sr       <= '0;
         r_diff_sr    <= '0;
         r_cnt        <= '0;
         r_brw        <= 1'b0;
         r_difference <= '0;
         r_borrow_out <= 1'b0;
      end else if (w_load) begin
         r_a_sr <= a;
         r_b_sr <= b;
         r_brw  <= borrow_in;
         r_cnt  <= '0;
      end else if (r_state == SHIFT) begin
         r_a_sr    <= {1'b0, r_a_sr[BIT_WIDTH-1:1]};
         r_b_sr    <= {1'b0, r_b_sr[BIT_WIDTH-1:1]};
         r_diff_sr <= w_diff_next[BIT_WIDTH-1:1];
         r_brw     <= w_bout;
         r_cnt     <= r_cnt + 1'b1;
         if (w_last) begin
            r_difference <= w_diff_next;
            r_borrow_out <= w_bout;
         end
      end
   end

`ifdef SUB_OVERFLOW_EN
   // On the last step the slice inputs hold the latched operand MSBs.
   logic r_overflow;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (w_last) begin
         r_overflow <= (r_a_sr[0] != r_b_sr[0]) && (w_d != r_a_sr[0]);
      end
   end

   assign overflow = r_overflow;
`endif

   assign busy       = (r_state == SHIFT);
   assign done       = (r_state == DONE);
   assign difference = r_difference;
   assign borrow_out = r_borrow_out;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor_nbit.sv
//==============================================================================
// Module  : tb_serial_subtractor_nbit
// Brief   : Scoreboard bench for serial_subtractor_nbit (BIT_WIDTH = 16).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_serial_subtractor_nbit;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         borrow_in;
   logic         busy;
   logic         done;
   logic [W-1:0] difference;
   logic         borrow_out;
`ifdef SUB_OVERFLOW_EN
   logic         overflow;
`endif

   serial_subtractor_nbit #(.BIT_WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .borrow_in  (borrow_in),
      .busy       (busy),
      .done       (done),
      .difference (difference),
      .borrow_out (borrow_out)
`ifdef SUB_OVERFLOW_EN
      ,
      .overflow   (overflow)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] diff;
      logic         brw;
      logic         ovf;
   } exp_t;

   exp_t sb[$];
   int   n_checks   = 0;
   int   n_errors   = 0;
   int   done_count = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
      exp_t       e;
      logic [W:0] r;
      r      = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
      e.diff = r[W-1:0];
      e.brw  = r[W];
      e.ovf  = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
      return e;
   endfunction

   // Scoreboard consumer: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (done) begin
         exp_t e;
         done_count++;
         if (sb.size() == 0) begin
            check_val("spurious_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check_val("difference", 32'(difference), 32'(e.diff));
            check_val("borrow_out", 32'(borrow_out), 32'(e.brw));
`ifdef SUB_OVERFLOW_EN
            check_val("overflow", 32'(overflow), 32'(e.ovf));
`endif
         end
      end
   end

   // Presents one start pulse; returns at the negedge after the sampling edge.
   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                        input bit expect_result);
      @(negedge clk);
      a         = ia;
      b         = ib;
      borrow_in = ibin;
      start     = 1'b1;
      if (expect_result) sb.push_back(model(ia, ib, ibin));
      @(negedge clk);
      start     = 1'b0;
      a         = W'($urandom);
      b         = W'($urandom);
      borrow_in = 1'($urandom);
      check_val("busy_after_start", 32'(busy), 32'd1);
   endtask

   // Edges are counted with the start-sampling edge as number 1.
   task automatic wait_done(input int edges_so_far, output int edges);
      edges = edges_so_far;
      while (!done && edges < 60) begin
         @(negedge clk);
         edges++;
      end
      if (!done) check_val("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
      int   e;
      exp_t x;
      x = model(ia, ib, ibin);
      issue(ia, ib, ibin, 1'b1);
      wait_done(1, e);
      check_val("latency", 32'(e), 32'd17);
      @(negedge clk);
      check_val("done_one_cycle", 32'(done), 32'd0);
      check_val("diff_hold", 32'(difference), 32'(x.diff));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int e;
      int base;
      int t1;
      int t2;

      rst       = 1'b1;
      start     = 1'b0;
      a         = '0;
      b         = '0;
      borrow_in = 1'b0;
      #12;
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_difference", 32'(difference), 32'd0);
      check_val("rst_borrow_out", 32'(borrow_out), 32'd0);
`ifdef SUB_OVERFLOW_EN
      check_val("rst_overflow", 32'(overflow), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

      run_op(16'h1234, 16'h0034, 1'b0);
      run_op(16'h0000, 16'h0001, 1'b0);
      run_op(16'h0005, 16'h0003, 1'b1);
      run_op(16'h8000, 16'h0001, 1'b0);
      run_op(16'h7FFF, 16'hFFFF, 1'b0);
      run_op(16'hFFFF, 16'hFFFF, 1'b1);
      for (int i = 0; i < 6; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom));
      end

      // A second start during SHIFT must be ignored.
      base = done_count;
      issue(16'h1111, 16'h0101, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      a     = 16'hFFFF;
      b     = 16'h0001;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(6, e);
      check_val("latency_ignore", 32'(e), 32'd17);
      repeat (25) @(negedge clk);
      check_val("ignore_done_count", 32'(done_count - base), 32'd1);

      // Reset mid-operation aborts without a done pulse.
      base = done_count;
      issue(16'hAAAA, 16'h5555, 1'b0, 1'b0);
      repeat (7) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_val("abort_busy", 32'(busy), 32'd0);
      check_val("abort_done", 32'(done), 32'd0);
      check_val("abort_difference", 32'(difference), 32'd0);
      check_val("abort_borrow_out", 32'(borrow_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      check_val("abort_no_done", 32'(done_count - base), 32'd0);
      run_op(16'h4321, 16'h1234, 1'b1);

      // start held high: back-to-back operations.
      @(negedge clk);
      a         = 16'h0F0F;
      b         = 16'h1234;
      borrow_in = 1'b1;
      start     = 1'b1;
      sb.push_back(model(16'h0F0F, 16'h1234, 1'b1));
      sb.push_back(model(16'h0F0F, 16'h1234, 1'b1));
      e  = 0;
      t1 = 0;
      t2 = 0;
      while (t2 == 0 && e < 80) begin
         @(negedge clk);
         e++;
         if (done) begin
            if (t1 == 0) t1 = e;
            else         t2 = e;
         end
      end
      start = 1'b0;
      check_val("b2b_first_latency", 32'(t1), 32'd17);
      check_val("b2b_period", 32'(t2 - t1), 32'd18);

      repeat (25) @(negedge clk);
      check_val("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
